// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encodings, reset level,
// default bus widths and the zero data word.
package mem_bus_arbiter_pkg;

  localparam int BusAddrW = 32;
  localparam int BusDataW = 32;

  localparam logic RstEnable = 1'b1;

  localparam logic [BusDataW-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbBusyI = 2'd1,
    ArbBusyD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Bus watchdog: counts cycles spent waiting for a slave acknowledge and flags
// the cycle in which the count would reach TIMEOUT.
module bus_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LastCount = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // The increment taken at this edge would reach TIMEOUT, so abort now.
  assign expired = enable && (count_reg == LastCount);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-style bus between instruction fetch and the mem-stage port.
// Data has fixed priority; one transaction at a time with a hang watchdog.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = BusAddrW,
  parameter int DATA_W  = BusDataW,
  parameter int TIMEOUT = 255,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,

  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [SEL_W-1:0]  mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,

  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o,

  output logic              stall_if_o,
  output logic              stall_mem_o
);

  arb_state_e state_reg, state_next;

  logic              bus_req_reg,   bus_req_next;
  logic              bus_we_reg,    bus_we_next;
  logic [SEL_W-1:0]  bus_sel_reg,   bus_sel_next;
  logic [ADDR_W-1:0] bus_addr_reg,  bus_addr_next;
  logic [DATA_W-1:0] bus_wdata_reg, bus_wdata_next;
  logic [DATA_W-1:0] if_rdata_reg,  if_rdata_next;
  logic [DATA_W-1:0] mem_rdata_reg, mem_rdata_next;
  logic              if_ack_reg,    if_ack_next;
  logic              mem_ack_reg,   mem_ack_next;
  logic              bus_err_reg,   bus_err_next;

  logic              busy;
  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expired;
  logic [DATA_W-1:0] done_rdata;

  assign busy      = (state_reg != ArbIdle);
  assign wd_clear  = ~busy;
  assign wd_enable = busy & ~bus_ack_i;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_next     = state_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_sel_next   = bus_sel_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    mem_rdata_next = mem_rdata_reg;
    if_ack_next    = 1'b0;
    mem_ack_next   = 1'b0;
    bus_err_next   = 1'b0;
    // A real slave ack beats a coincident watchdog expiry.
    done_rdata     = bus_ack_i ? bus_rdata_i : DATA_W'(ZeroWord);

    case (state_reg)
      ArbIdle: begin
        if (mem_req_i) begin
          state_next     = ArbBusyD;
          bus_req_next   = 1'b1;
          bus_we_next    = mem_we_i;
          bus_sel_next   = mem_sel_i;
          bus_addr_next  = mem_addr_i;
          bus_wdata_next = mem_wdata_i;
        end else if (if_req_i) begin
          state_next    = ArbBusyI;
          bus_req_next  = 1'b1;
          bus_we_next   = 1'b0;
          bus_sel_next  = {SEL_W{1'b1}};
          bus_addr_next = if_addr_i;
        end
      end

      ArbBusyI, ArbBusyD: begin
        if (bus_ack_i || wd_expired) begin
          state_next   = ArbIdle;
          bus_req_next = 1'b0;
          bus_err_next = ~bus_ack_i;
          if (state_reg == ArbBusyI) begin
            if_ack_next   = 1'b1;
            if_rdata_next = done_rdata;
          end else begin
            mem_ack_next = 1'b1;
            // Stores leave the load data register untouched.
            if (!bus_we_reg) begin
              mem_rdata_next = done_rdata;
            end
          end
        end
      end

      default: begin
        state_next   = ArbIdle;
        bus_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_reg     <= ArbIdle;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_sel_reg   <= '0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      if_rdata_reg  <= DATA_W'(ZeroWord);
      mem_rdata_reg <= DATA_W'(ZeroWord);
      if_ack_reg    <= 1'b0;
      mem_ack_reg   <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_sel_reg   <= bus_sel_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      mem_rdata_reg <= mem_rdata_next;
      if_ack_reg    <= if_ack_next;
      mem_ack_reg   <= mem_ack_next;
      bus_err_reg   <= bus_err_next;
    end
  end

  assign bus_req_o   = bus_req_reg;
  assign bus_we_o    = bus_we_reg;
  assign bus_sel_o   = bus_sel_reg;
  assign bus_addr_o  = bus_addr_reg;
  assign bus_wdata_o = bus_wdata_reg;
  assign bus_err_o   = bus_err_reg;
  assign if_rdata_o  = if_rdata_reg;
  assign if_ack_o    = if_ack_reg;
  assign mem_rdata_o = mem_rdata_reg;
  assign mem_ack_o   = mem_ack_reg;

  assign stall_if_o  = if_req_i & ~if_ack_reg;
  assign stall_mem_o = mem_req_i & ~mem_ack_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed cycle table, reset-abandon sequence and
// a randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;
  logic        stall_if_o;
  logic        stall_mem_o;

  mem_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ack_o    (if_ack_o),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_sel_i   (mem_sel_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_ack_o   (mem_ack_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_sel_o   (bus_sel_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .bus_err_o   (bus_err_o),
    .stall_if_o  (stall_if_o),
    .stall_mem_o (stall_mem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected during that cycle.
  typedef struct {
    logic        mreq;
    logic        mwe;
    logic [3:0]  msel;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        ireq;
    logic [31:0] iaddr;
    logic        back;
    logic [31:0] brdata;
    logic        e_breq;
    logic        e_bwe;
    logic [3:0]  e_bsel;
    logic [31:0] e_baddr;
    logic [31:0] e_bwdata;
    logic        e_mack;
    logic        e_iack;
    logic        e_err;
    logic        e_smem;
    logic        e_sif;
    logic [31:0] e_mrd;
    logic [31:0] e_ird;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t vecs[$];
  vec_t cur;
  vec_t zv;

  // Reference model state for the randomized run.
  bit          busy;
  int          port;
  int          done_c;
  int          ack_c;
  int          lat;
  int          n_txn;
  bit          timed_out;
  bit          if_pend;
  bit          mem_pend;
  bit          in_win;
  bit          ack_now;
  logic        ex_we;
  logic        tx_we;
  logic [3:0]  ex_sel;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [31:0] tx_rd;
  logic [31:0] e_if_rd;
  logic [31:0] e_mem_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    mem_req_i   = v.mreq;
    mem_we_i    = v.mwe;
    mem_sel_i   = v.msel;
    mem_addr_i  = v.maddr;
    mem_wdata_i = v.mwdata;
    if_req_i    = v.ireq;
    if_addr_i   = v.iaddr;
    bus_ack_i   = v.back;
    bus_rdata_i = v.brdata;
  endtask

  task automatic cmp(input string tag, input int idx, input vec_t v);
    string p;
    p = $sformatf("%s[%0d]", tag, idx);
    chk({p, " bus_req"}, 32'(bus_req_o), 32'(v.e_breq));
    if (v.e_breq) begin
      chk({p, " bus_addr"}, bus_addr_o, v.e_baddr);
      chk({p, " bus_we"}, 32'(bus_we_o), 32'(v.e_bwe));
      chk({p, " bus_sel"}, 32'(bus_sel_o), 32'(v.e_bsel));
      if (v.e_bwe) chk({p, " bus_wdata"}, bus_wdata_o, v.e_bwdata);
    end
    chk({p, " mem_ack"}, 32'(mem_ack_o), 32'(v.e_mack));
    chk({p, " if_ack"}, 32'(if_ack_o), 32'(v.e_iack));
    chk({p, " bus_err"}, 32'(bus_err_o), 32'(v.e_err));
    chk({p, " stall_mem"}, 32'(stall_mem_o), 32'(v.e_smem));
    chk({p, " stall_if"}, 32'(stall_if_o), 32'(v.e_sif));
    chk({p, " mem_rdata"}, mem_rdata_o, v.e_mrd);
    chk({p, " if_rdata"}, if_rdata_o, v.e_ird);
  endtask

  task automatic add(input vec_t v, input int n);
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input string tag, input int idx, input vec_t v);
    drive(v);
    #1;
    cmp(tag, idx, v);
    step();
  endtask

  initial begin
    zv = vec_t'{'0, '0, '0, '0, '0, '0, '0, '0, '0,
                '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0};

    // Single load, slave acks in the third bus cycle.
    add(vec_t'{1'b1, '0, 4'hF, 32'h8000_0010, '0, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, '0, '0, '0, 1'b1, '0, '0, '0}, 1);
    add(vec_t'{1'b1, '0, 4'hF, 32'h8000_0010, '0, '0, '0, '0, '0,
               1'b1, '0, 4'hF, 32'h8000_0010, '0, '0, '0, '0, 1'b1, '0, '0, '0}, 2);
    add(vec_t'{1'b1, '0, 4'hF, 32'h8000_0010, '0, '0, '0, 1'b1, 32'hDEAD_BEEF,
               1'b1, '0, 4'hF, 32'h8000_0010, '0, '0, '0, '0, 1'b1, '0, '0, '0}, 1);
    add(vec_t'{'0, '0, '0, '0, '0, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, 1'b1, '0, '0, '0, '0, 32'hDEAD_BEEF, '0}, 1);
    // Contention: data first, fetch afterwards.
    add(vec_t'{1'b1, '0, 4'hF, 32'h2000, '0, 1'b1, 32'h1000, '0, '0,
               '0, '0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b1, 32'hDEAD_BEEF, '0}, 1);
    add(vec_t'{1'b1, '0, 4'hF, 32'h2000, '0, 1'b1, 32'h1000, 1'b1, 32'hAAAA_5555,
               1'b1, '0, 4'hF, 32'h2000, '0, '0, '0, '0, 1'b1, 1'b1, 32'hDEAD_BEEF, '0}, 1);
    add(vec_t'{'0, '0, '0, '0, '0, 1'b1, 32'h1000, '0, '0,
               '0, '0, '0, '0, '0, 1'b1, '0, '0, '0, 1'b1, 32'hAAAA_5555, '0}, 1);
    add(vec_t'{'0, '0, '0, '0, '0, 1'b1, 32'h1000, 1'b1, 32'h1357_9BDF,
               1'b1, '0, 4'hF, 32'h1000, '0, '0, '0, '0, '0, 1'b1, 32'hAAAA_5555, '0}, 1);
    add(vec_t'{'0, '0, '0, '0, '0, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, '0, 1'b1, '0, '0, '0, 32'hAAAA_5555, 32'h1357_9BDF}, 1);
    // Store: bus shows we/sel/wdata, load data register unchanged.
    add(vec_t'{1'b1, 1'b1, 4'h3, 32'h3000, 32'h1234_5678, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, '0, '0, '0, 1'b1, '0, 32'hAAAA_5555, 32'h1357_9BDF}, 1);
    add(vec_t'{1'b1, 1'b1, 4'h3, 32'h3000, 32'h1234_5678, '0, '0, '0, '0,
               1'b1, 1'b1, 4'h3, 32'h3000, 32'h1234_5678, '0, '0, '0, 1'b1, '0,
               32'hAAAA_5555, 32'h1357_9BDF}, 1);
    add(vec_t'{1'b1, 1'b1, 4'h3, 32'h3000, 32'h1234_5678, '0, '0, 1'b1, 32'hFFFF_FFFF,
               1'b1, 1'b1, 4'h3, 32'h3000, 32'h1234_5678, '0, '0, '0, 1'b1, '0,
               32'hAAAA_5555, 32'h1357_9BDF}, 1);
    add(vec_t'{'0, '0, '0, '0, '0, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, 1'b1, '0, '0, '0, '0, 32'hAAAA_5555, 32'h1357_9BDF}, 1);
    // Timeout: four strobe cycles, then ack + err with zero data.
    add(vec_t'{1'b1, '0, 4'hF, 32'h4000, '0, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, '0, '0, '0, 1'b1, '0, 32'hAAAA_5555, 32'h1357_9BDF}, 1);
    add(vec_t'{1'b1, '0, 4'hF, 32'h4000, '0, '0, '0, '0, '0,
               1'b1, '0, 4'hF, 32'h4000, '0, '0, '0, '0, 1'b1, '0,
               32'hAAAA_5555, 32'h1357_9BDF}, TMO);
    add(vec_t'{'0, '0, '0, '0, '0, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, 1'b1, '0, 1'b1, '0, '0, '0, 32'h1357_9BDF}, 1);
    // Ack in the expiry cycle: ack wins, no error.
    add(vec_t'{1'b1, '0, 4'hF, 32'h5000, '0, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, '0, '0, '0, 1'b1, '0, '0, 32'h1357_9BDF}, 1);
    add(vec_t'{1'b1, '0, 4'hF, 32'h5000, '0, '0, '0, '0, '0,
               1'b1, '0, 4'hF, 32'h5000, '0, '0, '0, '0, 1'b1, '0, '0, 32'h1357_9BDF}, TMO - 1);
    add(vec_t'{1'b1, '0, 4'hF, 32'h5000, '0, '0, '0, 1'b1, 32'hCAFE_F00D,
               1'b1, '0, 4'hF, 32'h5000, '0, '0, '0, '0, 1'b1, '0, '0, 32'h1357_9BDF}, 1);
    add(vec_t'{'0, '0, '0, '0, '0, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, 1'b1, '0, '0, '0, '0, 32'hCAFE_F00D, 32'h1357_9BDF}, 1);
    // Stray slave ack while idle is ignored.
    add(vec_t'{'0, '0, '0, '0, '0, '0, '0, 1'b1, 32'h1111_1111,
               '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 32'hCAFE_F00D, 32'h1357_9BDF}, 1);
    add(vec_t'{'0, '0, '0, '0, '0, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 32'hCAFE_F00D, 32'h1357_9BDF}, 1);

    // Reset values.
    rst = 1'b1;
    drive(zv);
    step();
    step();
    chk("reset bus_we", 32'(bus_we_o), 32'h0);
    chk("reset bus_sel", 32'(bus_sel_o), 32'h0);
    chk("reset bus_addr", bus_addr_o, 32'h0);
    chk("reset bus_wdata", bus_wdata_o, 32'h0);
    cmp("reset", 0, zv);
    rst = 1'b0;

    foreach (vecs[i]) run_cycle("table", i, vecs[i]);

    // Reset while a fetch is on the bus: strobe dropped, no ack, refetch works.
    cur = vec_t'{'0, '0, '0, '0, '0, 1'b1, 32'h6000, '0, '0,
                 '0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1, 32'hCAFE_F00D, 32'h1357_9BDF};
    run_cycle("rstmid", 0, cur);
    rst = 1'b1;
    cur.e_breq = 1'b1; cur.e_bsel = 4'hF; cur.e_baddr = 32'h6000;
    run_cycle("rstmid", 1, cur);
    rst = 1'b0;
    cur.e_breq = 1'b0; cur.e_mrd = '0; cur.e_ird = '0;
    run_cycle("rstmid", 2, cur);
    cur.back = 1'b1; cur.brdata = 32'h0BAD_C0DE; cur.e_breq = 1'b1;
    run_cycle("rstmid", 3, cur);
    cur = zv;
    cur.e_iack = 1'b1; cur.e_ird = 32'h0BAD_C0DE;
    run_cycle("rstmid", 4, cur);

    // Randomized run against a transaction-level model.
    rst = 1'b1;
    drive(zv);
    step();
    rst = 1'b0;
    busy = 0; port = 0; done_c = 0; ack_c = -1; timed_out = 0;
    if_pend = 0; mem_pend = 0; n_txn = 0;
    e_if_rd = '0; e_mem_rd = '0; tx_rd = '0; tx_we = 1'b0;
    ex_we = 1'b0; ex_sel = '0; ex_addr = '0; ex_wdata = '0;
    cur = zv;
    for (int t = 0; t < 2000; t++) begin
      in_win  = busy && (t < done_c);
      ack_now = busy && (t == done_c);

      // Requesters keep a request up until its ack, and may issue a new one then.
      if (!if_pend || (ack_now && port == 0)) begin
        cur.ireq  = ($urandom_range(0, 1) == 1);
        cur.iaddr = $urandom;
        if_pend   = cur.ireq;
      end
      if (!mem_pend || (ack_now && port == 1)) begin
        cur.mreq   = ($urandom_range(0, 2) == 0);
        cur.mwe    = 1'($urandom_range(0, 1));
        cur.msel   = 4'($urandom);
        cur.maddr  = $urandom;
        cur.mwdata = $urandom;
        mem_pend   = cur.mreq;
      end

      cur.brdata = $urandom;
      if (in_win) cur.back = (t == ack_c);
      else        cur.back = ($urandom_range(0, 3) == 0);
      if (in_win && t == ack_c) tx_rd = cur.brdata;

      if (ack_now) begin
        if (port == 0)   e_if_rd  = timed_out ? 32'h0 : tx_rd;
        else if (!tx_we) e_mem_rd = timed_out ? 32'h0 : tx_rd;
      end
      cur.e_breq   = in_win;
      cur.e_bwe    = ex_we;
      cur.e_bsel   = ex_sel;
      cur.e_baddr  = ex_addr;
      cur.e_bwdata = ex_wdata;
      cur.e_mack   = ack_now && (port == 1);
      cur.e_iack   = ack_now && (port == 0);
      cur.e_err    = ack_now && timed_out;
      cur.e_smem   = cur.mreq && !cur.e_mack;
      cur.e_sif    = cur.ireq && !cur.e_iack;
      cur.e_mrd    = e_mem_rd;
      cur.e_ird    = e_if_rd;

      drive(cur);
      #1;
      cmp("rand", t, cur);

      // An idle arbiter takes data first, else fetch; the slave latency decides
      // between a normal completion and a watchdog abort after TMO strobe cycles.
      if (!in_win) begin
        if (cur.mreq || cur.ireq) begin
          busy     = 1;
          port     = cur.mreq ? 1 : 0;
          ex_addr  = cur.mreq ? cur.maddr : cur.iaddr;
          ex_we    = cur.mreq ? cur.mwe : 1'b0;
          ex_sel   = cur.mreq ? cur.msel : 4'hF;
          ex_wdata = cur.mreq ? cur.mwdata : ex_wdata;
          tx_we    = ex_we;
          lat      = int'($urandom_range(1, TMO + 2));
          if (lat <= TMO) begin
            ack_c = t + lat; done_c = t + lat + 1; timed_out = 0;
          end else begin
            ack_c = -1; done_c = t + TMO + 1; timed_out = 1;
          end
          n_txn++;
          $display("txn %0d cycle %0d port=%s addr=%h we=%0d latency=%0d abort=%0d",
                   n_txn, t, (port == 1) ? "mem" : "if", ex_addr, ex_we, lat, timed_out);
        end else begin
          busy = 0;
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the CPU's single external memory bus between instruction fetch and the mem-stage load/store port. Sits between the pipeline (fetch and mem stages, plus the stall controller) and the SRAM-style bus slave. Data requests take fixed priority over fetch. The block sequences one bus transaction at a time, aborts hung transactions with a watchdog, and raises per-port stall requests until each transaction completes.

## Interface
- `ADDR_W`, 32, bus address width
- `DATA_W`, 32, bus data width; `SEL_W = DATA_W/8`
- `TIMEOUT`, 255, max cycles waiting for `bus_ack_i` before abort; must be ≥ 1
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `if_req_i` in 1: fetch request, held until `if_ack_o`
- `if_addr_i` in ADDR_W: fetch address
- `if_rdata_o` out DATA_W: fetched word
- `if_ack_o` out 1: one-cycle completion pulse
- `mem_req_i` in 1: data request, held until `mem_ack_o`
- `mem_we_i` in 1: 1 = store, 0 = load
- `mem_sel_i` in SEL_W: byte enables
- `mem_addr_i` in ADDR_W: data address
- `mem_wdata_i` in DATA_W: store data
- `mem_rdata_o` out DATA_W: load data
- `mem_ack_o` out 1: one-cycle completion pulse
- `bus_req_o`, `bus_we_o` out 1: bus strobe and write enable
- `bus_sel_o` out SEL_W: bus byte enables
- `bus_addr_o` out ADDR_W: bus address
- `bus_wdata_o` out DATA_W: bus write data
- `bus_rdata_i` in DATA_W: bus read data
- `bus_ack_i` in 1: slave completion
- `bus_err_o` out 1: one-cycle pulse on watchdog abort, coincident with the aborted port's ack
- `stall_if_o`, `stall_mem_o` out 1: stall requests to the pipeline controller

## Operation
- FSM states: `IDLE`, `BUSY_I`, `BUSY_D`.
- **IDLE**
  - If `mem_req_i`: latch the data-side request into the bus registers and go to `BUSY_D`.
  - Else if `if_req_i`: latch the fetch address, set `we=0`, set `sel` to all ones, and go to `BUSY_I`.
- **BUSY_x**
  - `bus_*_o` are held stable from registers and `bus_req_o=1`.
  - On `bus_ack_i`:
    - Capture `bus_rdata_i` into the port's rdata register.
    - Pulse that port's ack.
    - Drop `bus_req_o`.
    - Return to `IDLE`.
  - For stores, `mem_rdata_o` is unchanged.
- **Watchdog**
  - Counter cleared on entry to `BUSY_x` and incremented each cycle without ack.
  - When the count reaches `TIMEOUT`:
    - Abort the transaction.
    - Pulse the port's ack and `bus_err_o`.
    - Load rdata with zero.
    - Return to `IDLE`.
  - Counter width is `$clog2(TIMEOUT+1)`.
- **Stalls** (combinational):
  - `stall_mem_o = mem_req_i & ~mem_ack_o`
  - `stall_if_o = if_req_i & ~if_ack_o`
- **Requester drops its req mid-transaction:** the transaction still completes and the ack still pulses; the requester ignores it.
- **Both requests in IDLE:** data wins. Fetch is served on the next IDLE cycle if still requested. Fetch starvation is acceptable because the mem stage stalls the front end.
- **Reset values:**
  - All `bus_*_o` = 0.
  - Acks, `bus_err_o` = 0.
  - rdata registers = `32'h0`.
  - State = `IDLE`; watchdog = 0.
- **Reset mid-transaction:** `bus_req_o` drops at the reset edge and no ack is issued. The slave must tolerate an abandoned strobe.

## Timing
- Request sampled at edge 0 → `bus_req_o` high after edge 1 (cycle 1).
- Slave asserts `bus_ack_i` in cycle k → port ack and rdata valid in cycle k+1, with `bus_req_o` low and state `IDLE` in that same cycle.
- Minimum transaction: 3 cycles request-to-ack (ack in cycle 1 → port ack in cycle 2).
- A new request present in cycle k+1 is sampled at the end of that cycle. Back-to-back throughput is therefore one transaction per (slave latency + 2) cycles.
- `bus_ack_i` outside `BUSY_x` is ignored.
- Ack arriving in the same cycle the watchdog expires: the ack wins, with no `bus_err_o`.

## Structure
- Shared defines package holds:
  - FSM state encodings (`ArbIdle`, `ArbBusyI`, `ArbBusyD`)
  - `ZeroWord`
  - `RstEnable`
  - Bus width macros
- One sub-module, `bus_watchdog`: a `TIMEOUT` counter with `clear`/`enable` inputs and an `expired` output.

## Test plan
- **Single load:** `mem_req_i=1`, addr `0x80000010`, slave acks after 2 cycles with `0xDEADBEEF` → `mem_ack_o` pulses in cycle 4, `mem_rdata_o=0xDEADBEEF`, and `stall_mem_o` is high in cycles 0–3.
- **Contention:** `if_req_i` and `mem_req_i` rise in the same cycle → the data transaction goes on the bus first, then fetch. `if_ack_o` pulses after `mem_ack_o`.
- **Store:** `mem_we_i=1`, `sel=4'b0011`, wdata `0x12345678` → the bus sees `we=1`, `sel=0011` and stable data until ack. `mem_rdata_o` is unchanged.
- **Timeout:** `TIMEOUT=4`, slave never acks → `mem_ack_o` and `bus_err_o` pulse together 4 cycles after `bus_req_o` rises, with rdata 0.
- **Ack/expiry collision:** `TIMEOUT=4`, the slave acks in the same cycle the watchdog count reaches 4 → the port ack pulses with `bus_rdata_i` captured and `bus_err_o` stays 0.
- **Reset mid-transaction:** assert `rst` while in `BUSY_I` → `bus_req_o` is 0 next cycle, there is no `if_ack_o`, and a subsequent fetch completes normally.
